// File: rtl/horizontal_projection_digits_if.sv
// Pixel stream, column windows and digit row bounds exchanged between the
// vertical projection stage, this block and the digit recognizer.
interface horizontal_projection_digits_if;
  logic        vsync;
  logic        href;
  logic        clken;
  logic        bin;
  logic [10:0] line_left1;
  logic [10:0] line_left2;
  logic [10:0] line_left3;
  logic [10:0] line_left4;
  logic [10:0] line_right1;
  logic [10:0] line_right2;
  logic [10:0] line_right3;
  logic [10:0] line_right4;
  logic [10:0] line_top1;
  logic [10:0] line_top2;
  logic [10:0] line_top3;
  logic [10:0] line_top4;
  logic [10:0] line_bottom1;
  logic [10:0] line_bottom2;
  logic [10:0] line_bottom3;
  logic [10:0] line_bottom4;
  logic        frame_done;

  modport master (
    output vsync, href, clken, bin,
    output line_left1, line_left2, line_left3, line_left4,
    output line_right1, line_right2, line_right3, line_right4,
    input  line_top1, line_top2, line_top3, line_top4,
    input  line_bottom1, line_bottom2, line_bottom3, line_bottom4,
    input  frame_done
  );

  modport slave (
    input  vsync, href, clken, bin,
    input  line_left1, line_left2, line_left3, line_left4,
    input  line_right1, line_right2, line_right3, line_right4,
    output line_top1, line_top2, line_top3, line_top4,
    output line_bottom1, line_bottom2, line_bottom3, line_bottom4,
    output frame_done
  );
endinterface

// File: rtl/horizontal_projection_digits.sv
// Horizontal projection: per column window, counts white pixels per row and
// records the first run of ink rows (top/bottom) of each digit in a frame.
module horizontal_projection_digits #(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int ROW_THRESH     = 3
) (
  input logic clk,
  input logic reset,
  horizontal_projection_digits_if.slave bus
);

  localparam logic [10:0] X_LAST = 11'(DISPLAY_WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(DISPLAY_HEIGHT - 1);
  localparam logic [10:0] THRESH = 11'(ROW_THRESH);

  typedef enum logic [1:0] {IDLE, INK, DONE} state_t;

  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic        vsync_d;
  logic        synced;
  logic [10:0] win_l    [4];
  logic [10:0] win_r    [4];
  logic [9:0]  row_cnt  [4];
  logic [10:0] top_int  [4];
  logic [10:0] bot_int  [4];
  state_t      state    [4];
  logic [10:0] out_top  [4];
  logic [10:0] out_bot  [4];
  logic        done_q;

  logic [10:0] left_in  [4];
  logic [10:0] right_in [4];
  logic [3:0]  hit;
  logic [3:0]  valid;
  logic [10:0] sum      [4];
  logic        row_end;
  logic        frame_end;

  // Gather the per-window interface signals into indexable arrays
  always_comb begin
    left_in[0]  = bus.line_left1;
    left_in[1]  = bus.line_left2;
    left_in[2]  = bus.line_left3;
    left_in[3]  = bus.line_left4;
    right_in[0] = bus.line_right1;
    right_in[1] = bus.line_right2;
    right_in[2] = bus.line_right3;
    right_in[3] = bus.line_right4;
  end

  // Window hit for the current pixel and the row total including that pixel
  always_comb begin
    row_end   = bus.clken && (x_cnt == X_LAST);
    frame_end = vsync_d && !bus.vsync && synced;
    for (int unsigned k = 0; k < 4; k++) begin
      valid[k] = win_r[k] > win_l[k];
      hit[k]   = bus.bin && (x_cnt >= win_l[k]) && (x_cnt <= win_r[k]);
      sum[k]   = {1'b0, row_cnt[k]} + {10'd0, hit[k]};
    end
  end

  // Counters, window latch, per-window ink FSMs and frame-end output update.
  // synced is only set once vsync has been seen low, so a frame interrupted by
  // reset is never published when its vsync finally falls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      vsync_d <= 1'b0;
      synced  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        win_l[k]   <= '0;
        win_r[k]   <= '0;
        row_cnt[k] <= '0;
        top_int[k] <= '0;
        bot_int[k] <= '0;
        state[k]   <= IDLE;
        out_top[k] <= '0;
        out_bot[k] <= '0;
      end
    end else begin
      vsync_d <= bus.vsync;
      done_q  <= frame_end;
      if (frame_end) begin
        for (int unsigned k = 0; k < 4; k++) begin
          out_top[k] <= top_int[k];
          out_bot[k] <= bot_int[k];
        end
      end
      if (!bus.vsync) begin
        synced <= 1'b1;
        x_cnt  <= '0;
        y_cnt  <= '0;
        for (int unsigned k = 0; k < 4; k++) begin
          win_l[k]   <= left_in[k];
          win_r[k]   <= right_in[k];
          row_cnt[k] <= '0;
          top_int[k] <= '0;
          bot_int[k] <= '0;
          state[k]   <= IDLE;
        end
      end else if (bus.clken) begin
        if (row_end) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 11'd1;
          for (int unsigned k = 0; k < 4; k++) begin
            row_cnt[k] <= '0;
            if (valid[k]) begin
              unique case (state[k])
                IDLE: if (sum[k] >= THRESH) begin
                  top_int[k] <= y_cnt;
                  state[k]   <= INK;
                end
                INK: if (sum[k] < THRESH) begin
                  bot_int[k] <= y_cnt - 11'd1;
                  state[k]   <= DONE;
                end else if (y_cnt == Y_LAST) begin
                  bot_int[k] <= Y_LAST;
                  state[k]   <= DONE;
                end
                default: ;
              endcase
            end
          end
        end else begin
          x_cnt <= x_cnt + 11'd1;
          for (int unsigned k = 0; k < 4; k++) begin
            if (hit[k] && (row_cnt[k] != '1)) row_cnt[k] <= row_cnt[k] + 10'd1;
          end
        end
      end
    end
  end

  assign bus.line_top1    = out_top[0];
  assign bus.line_top2    = out_top[1];
  assign bus.line_top3    = out_top[2];
  assign bus.line_top4    = out_top[3];
  assign bus.line_bottom1 = out_bot[0];
  assign bus.line_bottom2 = out_bot[1];
  assign bus.line_bottom3 = out_bot[2];
  assign bus.line_bottom4 = out_bot[3];
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_horizontal_projection_digits.sv
// Directed bench for horizontal_projection_digits on a reduced 40x60 frame so
// each frame costs 2400 pixel clocks; row/column coordinates of the test plan
// are scaled into that frame.
module tb_horizontal_projection_digits;

  localparam int W = 40;
  localparam int H = 60;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  horizontal_projection_digits_if bus ();

  horizontal_projection_digits #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .ROW_THRESH    (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [10:0] got, logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_outputs(string tag, int t1, int t2, int t3, int t4,
                                int b1, int b2, int b3, int b4);
    check({tag, ".top1"}, bus.line_top1, 11'(t1));
    check({tag, ".top2"}, bus.line_top2, 11'(t2));
    check({tag, ".top3"}, bus.line_top3, 11'(t3));
    check({tag, ".top4"}, bus.line_top4, 11'(t4));
    check({tag, ".bot1"}, bus.line_bottom1, 11'(b1));
    check({tag, ".bot2"}, bus.line_bottom2, 11'(b2));
    check({tag, ".bot3"}, bus.line_bottom3, 11'(b3));
    check({tag, ".bot4"}, bus.line_bottom4, 11'(b4));
  endtask

  task automatic drive_windows(int l1, int r1, int l2, int r2,
                               int l3, int r3, int l4, int r4);
    bus.line_left1  = 11'(l1);
    bus.line_right1 = 11'(r1);
    bus.line_left2  = 11'(l2);
    bus.line_right2 = 11'(r2);
    bus.line_left3  = 11'(l3);
    bus.line_right3 = 11'(r3);
    bus.line_left4  = 11'(l4);
    bus.line_right4 = 11'(r4);
  endtask

  // Windows are presented while vsync is low so they get latched
  task automatic set_windows(int l1, int r1, int l2, int r2,
                             int l3, int r3, int l4, int r4);
    bus.vsync = 1'b0;
    drive_windows(l1, r1, l2, r2, l3, r3, l4, r4);
    repeat (4) @(negedge clk);
  endtask

  function automatic logic pix(int mode, int x, int y);
    case (mode)
      0: return (y >= 20 && y <= 29 && x >= 11 && x <= 16) ||
                (y <= 5 && x >= 30 && x <= 35);
      1: return (y >= 5 && y <= 8) && (x == 9 || x == 12 || x == 13 || x == 21);
      2: return (y >= 5 && y <= 8) &&
                (x == 9 || x == 10 || x == 15 || x == 20 || x == 21);
      3: return (x >= 1 && x <= 4 && ((y >= 10 && y <= 15) || (y >= 20 && y <= 25))) ||
                (x >= 11 && x <= 16 && y >= 20 && y <= 29) ||
                (x >= 26 && x <= 30 && y >= 50 && y <= 59) ||
                (x >= 36 && x <= 39 && y == 40);
      4: return x >= 11 && x <= 16 && y >= 20 && y <= 40;
      default: return 1'b0;
    endcase
  endfunction

  // One frame of `rows` rows; optional clken gaps, mid-frame window change,
  // and a 5-cycle reset at the start of row rst_row (negative = none)
  task automatic run_frame(string tag, int mode, int rows, bit gaps, bit change,
                           int rst_row);
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (2) @(negedge clk);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < W; x++) begin
        if (change && y == 3 && x == 0) drive_windows(0, 39, 0, 39, 0, 39, 0, 39);
        if (y == rst_row && x == 0) begin
          reset     = 1'b0;
          bus.clken = 1'b0;
          repeat (5) @(negedge clk);
          expect_outputs({tag, ".midreset"}, 0, 0, 0, 0, 0, 0, 0, 0);
          check({tag, ".midreset.done"}, 11'(bus.frame_done), 11'd0);
          reset = 1'b1;
        end
        if (gaps) begin
          for (int g = 0; g < 4 && $urandom_range(99) < 30; g++) begin
            bus.clken = 1'b0;
            bus.bin   = 1'($urandom);
            @(negedge clk);
          end
        end
        bus.clken = 1'b1;
        bus.href  = 1'b1;
        bus.bin   = pix(mode, x, y);
        @(negedge clk);
      end
    end
    bus.clken = 1'b0;
    bus.bin   = 1'b0;
    bus.href  = 1'b0;
    repeat (2) @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    check({tag, ".done_pulse"}, 11'(bus.frame_done), (rst_row < 0) ? 11'd1 : 11'd0);
    @(negedge clk);
    check({tag, ".done_clear"}, 11'(bus.frame_done), 11'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.clken = 1'b0;
    bus.bin   = 1'b0;
    drive_windows(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    expect_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.done", 11'(bus.frame_done), 11'd0);
    reset = 1'b1;

    set_windows(10, 20, 0, 0, 0, 0, 0, 0);
    run_frame("single", 0, H, 1'b0, 1'b0, -1);
    expect_outputs("single", 20, 0, 0, 0, 29, 0, 0, 0);

    run_frame("below_thresh", 1, H, 1'b0, 1'b0, -1);
    expect_outputs("below_thresh", 0, 0, 0, 0, 0, 0, 0, 0);

    run_frame("at_thresh", 2, H, 1'b0, 1'b0, -1);
    expect_outputs("at_thresh", 5, 0, 0, 0, 8, 0, 0, 0);

    set_windows(10, 20, 25, 35, 0, 5, 36, 39);
    run_frame("four", 3, H, 1'b0, 1'b0, -1);
    expect_outputs("four", 20, 50, 10, 40, 29, 59, 15, 40);

    set_windows(10, 20, 25, 35, 0, 5, 36, 39);
    run_frame("win_change", 3, H, 1'b0, 1'b1, -1);
    expect_outputs("win_change", 20, 50, 10, 40, 29, 59, 15, 40);

    set_windows(10, 20, 25, 35, 0, 5, 36, 39);
    run_frame("gaps", 3, H, 1'b1, 1'b0, -1);
    expect_outputs("gaps", 20, 50, 10, 40, 29, 59, 15, 40);

    set_windows(10, 20, 0, 0, 0, 0, 0, 0);
    run_frame("truncated", 4, 31, 1'b0, 1'b0, -1);
    expect_outputs("truncated", 20, 0, 0, 0, 0, 0, 0, 0);

    set_windows(10, 20, 25, 35, 0, 5, 36, 39);
    run_frame("reset_frame", 3, H, 1'b0, 1'b0, 25);
    expect_outputs("reset_frame", 0, 0, 0, 0, 0, 0, 0, 0);

    set_windows(10, 20, 25, 35, 0, 5, 36, 39);
    run_frame("after_reset", 3, H, 1'b0, 1'b0, -1);
    expect_outputs("after_reset", 20, 50, 10, 40, 29, 59, 15, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
